// File: rtl/row_uram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : row_uram_arbiter
//  Brief    : Round-robin barrier arbiter for a row's shared URAM, with a
//             valid/ready drain of the URAM once every core has had a session.
//  Revision : 1.0 - initial release
// ============================================================================
module row_uram_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int URAM_DEPTH  = 4096,
  parameter int DRAIN_WORDS = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CORES-1:0]    i_core_req,
  input  logic [NUM_CORES-1:0]    i_core_locked,
  output logic [NUM_CORES-1:0]    o_core_grant,
  output logic                    o_uram_emptied,
  input  logic [NUM_CORES-1:0]    i_core_uram_en,
  input  logic [NUM_CORES*12-1:0] i_core_uram_addr,
  input  logic [NUM_CORES*32-1:0] i_core_uram_wdata,
  input  logic [NUM_CORES-1:0]    i_core_uram_we,
  output logic                    o_drain_valid,
  output logic [11:0]             o_drain_addr,
  output logic [31:0]             o_drain_data,
  input  logic                    i_drain_ready
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] c_st_arb   = 2'd0;
  localparam logic [1:0] c_st_grant = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  localparam logic [NUM_CORES-1:0] c_one     = NUM_CORES'(1);
  localparam logic [NUM_CORES-1:0] c_all     = '1;
  localparam logic [11:0]          c_last    = 12'(DRAIN_WORDS - 1);
  localparam logic [PTR_W-1:0]     c_ptr_max = PTR_W'(NUM_CORES - 1);
  localparam logic [PTR_W:0]       c_ncores  = (PTR_W + 1)'(NUM_CORES);

  logic [1:0]           r_state;
  logic [NUM_CORES-1:0] r_done_mask;
  logic [NUM_CORES-1:0] r_grant;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     r_grant_idx;
  logic                 r_emptied;
  logic                 r_valid;
  logic [11:0]          r_out_addr;
  logic [31:0]          r_out_data;
  logic [11:0]          r_next_addr;
  logic                 r_all_issued;
  logic [31:0]          r_mem [URAM_DEPTH];

  logic [NUM_CORES-1:0] w_elig;
  logic                 w_found;
  logic [PTR_W-1:0]     w_pick;
  logic                 w_hold;
  logic                 w_sel_en;
  logic                 w_sel_we;
  logic [11:0]          w_wr_addr;
  logic [31:0]          w_wr_data;
  logic                 w_wr;
  logic                 w_drain_adv;
  logic                 w_drain_rd;

  assign w_elig = i_core_req & ~r_done_mask;

  // Rotating priority search starting at r_rr_ptr, modulo NUM_CORES.
  always_comb begin : p_pick
    logic [PTR_W:0] idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = {1'b0, r_rr_ptr} + (PTR_W + 1)'(i);
      if (idx >= c_ncores) idx = idx - c_ncores;
      if (!w_found && w_elig[idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = idx[PTR_W-1:0];
      end
    end
  end

  // Only the granted core reaches the URAM write port.
  always_comb begin
    w_sel_en  = 1'b0;
    w_sel_we  = 1'b0;
    w_wr_addr = '0;
    w_wr_data = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (r_grant[k]) begin
        w_sel_en  = w_sel_en  | i_core_uram_en[k];
        w_sel_we  = w_sel_we  | i_core_uram_we[k];
        w_wr_addr = w_wr_addr | i_core_uram_addr[12*k +: 12];
        w_wr_data = w_wr_data | i_core_uram_wdata[32*k +: 32];
      end
    end
  end

  assign w_hold      = |(r_grant & (i_core_req | i_core_locked));
  assign w_wr        = (r_state == c_st_grant) & w_sel_en & w_sel_we;
  assign w_drain_adv = r_valid & i_drain_ready;
  assign w_drain_rd  = (r_state == c_st_drain) & ~r_all_issued & (~r_valid | w_drain_adv);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_wr_addr] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_st_arb;
      r_done_mask  <= '0;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_grant_idx  <= '0;
      r_emptied    <= 1'b1;
      r_valid      <= 1'b0;
      r_out_addr   <= '0;
      r_out_data   <= '0;
      r_next_addr  <= '0;
      r_all_issued <= 1'b0;
    end else begin
      case (r_state)
        c_st_arb: begin
          if (r_done_mask == c_all) begin
            r_state      <= c_st_drain;
            r_next_addr  <= '0;
            r_all_issued <= 1'b0;
          end else if (w_found) begin
            r_grant     <= c_one << w_pick;
            r_grant_idx <= w_pick;
            r_emptied   <= 1'b0;
            r_state     <= c_st_grant;
          end
        end
        c_st_grant: begin
          if (!w_hold) begin
            r_grant     <= '0;
            r_done_mask <= r_done_mask | r_grant;
            r_rr_ptr    <= (r_grant_idx == c_ptr_max) ? '0 : r_grant_idx + PTR_W'(1);
            r_state     <= c_st_arb;
          end
        end
        c_st_drain: begin
          // Output register doubles as the one-cycle URAM read stage; it only
          // reloads when empty or being accepted, so stalled data stays put.
          if (w_drain_rd) begin
            r_valid    <= 1'b1;
            r_out_addr <= r_next_addr;
            r_out_data <= r_mem[r_next_addr];
            if (r_next_addr == c_last) r_all_issued <= 1'b1;
            else                       r_next_addr  <= r_next_addr + 12'd1;
          end else if (w_drain_adv) begin
            r_valid <= 1'b0;
          end
          if (w_drain_adv && (r_out_addr == c_last)) begin
            r_valid     <= 1'b0;
            r_done_mask <= '0;
            r_emptied   <= 1'b1;
            r_state     <= c_st_arb;
          end
        end
        default: r_state <= c_st_arb;
      endcase
    end
  end

  assign o_core_grant   = r_grant;
  assign o_uram_emptied = r_emptied;
  assign o_drain_valid  = r_valid;
  assign o_drain_addr   = r_out_addr;
  assign o_drain_data   = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_row_uram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_row_uram_arbiter
//  Brief    : Directed self-checking bench for row_uram_arbiter (4 cores,
//             16-word drain).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_row_uram_arbiter;

  localparam int NC = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   i_core_req;
  logic [NC-1:0]   i_core_locked;
  logic [NC-1:0]   o_core_grant;
  logic            o_uram_emptied;
  logic [NC-1:0]   i_core_uram_en;
  logic [NC*12-1:0] i_core_uram_addr;
  logic [NC*32-1:0] i_core_uram_wdata;
  logic [NC-1:0]   i_core_uram_we;
  logic            o_drain_valid;
  logic [11:0]     o_drain_addr;
  logic [31:0]     o_drain_data;
  logic            i_drain_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_mem   [DW];
  logic        exp_known [DW];

  always #5 clk = ~clk;

  row_uram_arbiter #(
    .NUM_CORES   (NC),
    .URAM_DEPTH  (4096),
    .DRAIN_WORDS (DW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .i_core_req        (i_core_req),
    .i_core_locked     (i_core_locked),
    .o_core_grant      (o_core_grant),
    .o_uram_emptied    (o_uram_emptied),
    .i_core_uram_en    (i_core_uram_en),
    .i_core_uram_addr  (i_core_uram_addr),
    .i_core_uram_wdata (i_core_uram_wdata),
    .i_core_uram_we    (i_core_uram_we),
    .o_drain_valid     (o_drain_valid),
    .o_drain_addr      (o_drain_addr),
    .o_drain_data      (o_drain_data),
    .i_drain_ready     (i_drain_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int k);
    return 4'(1 << k);
  endfunction

  function automatic logic [31:0] data_of(input int a);
    return (a == 5) ? 32'hDEADBEEF : (32'hA5A5_0000 | 32'(a));
  endfunction

  task automatic clr_wr();
    i_core_uram_en    = '0;
    i_core_uram_we    = '0;
    i_core_uram_addr  = '0;
    i_core_uram_wdata = '0;
  endtask

  task automatic drive_wr(input int k, input logic [11:0] a, input logic [31:0] d);
    i_core_uram_en[k]             = 1'b1;
    i_core_uram_we[k]             = 1'b1;
    i_core_uram_addr[12*k +: 12]  = a;
    i_core_uram_wdata[32*k +: 32] = d;
  endtask

  // Called right after grant[k] is seen: core drops req, holds locked for
  // nlock cycles writing nwr words from base, then releases.
  task automatic session(input int k, input int nlock, input int base, input int nwr);
    i_core_req[k]    = 1'b0;
    i_core_locked[k] = 1'b1;
    for (int c = 0; c < nlock; c++) begin
      clr_wr();
      if (c < nwr) begin
        drive_wr(k, 12'(base + c), data_of(base + c));
        exp_mem[base + c]   = data_of(base + c);
        exp_known[base + c] = 1'b1;
        if (k == 1 && base + c == 5) drive_wr(3, 12'd5, 32'h12345678);
      end
      tick();
      chk("grant_held", 32'(o_core_grant), 32'(oh(k)));
    end
    clr_wr();
    i_core_locked[k] = 1'b0;
    tick();
    chk("grant_drop", 32'(o_core_grant), 32'd0);
  endtask

  // Accepts nacc drain words with the ready pattern, checking order,
  // data and stability under backpressure.
  task automatic drain(input int nacc, input logic [31:0] pattern);
    int          got = 0;
    int          cyc = 0;
    logic        pv  = 1'b0;
    logic        pr  = 1'b0;
    logic [11:0] pa  = '0;
    logic [31:0] pd  = '0;
    while (got < nacc && cyc < 400) begin
      i_drain_ready = pattern[cyc % 32];
      chk("drain_no_grant", 32'(o_core_grant), 32'd0);
      chk("drain_emptied_low", 32'(o_uram_emptied), 32'd0);
      if (pv && !pr) begin
        chk("stall_valid", 32'(o_drain_valid), 32'd1);
        chk("stall_addr", 32'(o_drain_addr), 32'(pa));
        chk("stall_data", o_drain_data, pd);
      end
      if (o_drain_valid && i_drain_ready) begin
        chk("drain_addr", 32'(o_drain_addr), 32'(got));
        if (exp_known[got]) chk("drain_data", o_drain_data, exp_mem[got]);
        got++;
      end
      pv = o_drain_valid;
      pr = i_drain_ready;
      pa = o_drain_addr;
      pd = o_drain_data;
      tick();
      cyc++;
    end
    if (got < nacc) chk("drain_timeout_words", 32'(got), 32'(nacc));
    i_drain_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DW; i++) begin
      exp_mem[i]   = '0;
      exp_known[i] = 1'b0;
    end
    reset         = 1'b1;
    i_core_req    = '0;
    i_core_locked = '0;
    i_drain_ready = 1'b0;
    clr_wr();
    tick();
    tick();
    chk("rst_grant", 32'(o_core_grant), 32'd0);
    chk("rst_emptied", 32'(o_uram_emptied), 32'd1);
    chk("rst_valid", 32'(o_drain_valid), 32'd0);
    chk("rst_addr", 32'(o_drain_addr), 32'd0);
    chk("rst_data", o_drain_data, 32'd0);

    // Round 1: round robin 0..3, write isolation on addr 5, core2 re-requests.
    reset      = 1'b0;
    i_core_req = 4'b1111;
    tick();
    chk("r1_grant0", 32'(o_core_grant), 32'(oh(0)));
    chk("r1_emptied_fall", 32'(o_uram_emptied), 32'd0);
    session(0, 3, 0, 3);
    tick();
    chk("r1_grant1", 32'(o_core_grant), 32'(oh(1)));
    session(1, 3, 3, 3);
    tick();
    chk("r1_grant2", 32'(o_core_grant), 32'(oh(2)));
    session(2, 3, 6, 3);
    i_core_req[2] = 1'b1;
    tick();
    chk("r1_grant3_not2", 32'(o_core_grant), 32'(oh(3)));
    session(3, 3, 9, 3);
    drain(DW, 32'b1011_0011_1000_1101_0110_0100_1111_0010);
    chk("r1_valid_end", 32'(o_drain_valid), 32'd0);
    chk("r1_emptied_rise", 32'(o_uram_emptied), 32'd1);

    // Round 2: barrier release to core2, then a long lock hold on core0.
    tick();
    chk("r2_grant2", 32'(o_core_grant), 32'(oh(2)));
    chk("r2_emptied_fall", 32'(o_uram_emptied), 32'd0);
    i_core_req[1:0] = 2'b11;
    session(2, 1, 0, 0);
    tick();
    chk("r2_grant0", 32'(o_core_grant), 32'(oh(0)));
    i_core_req[0]    = 1'b0;
    i_core_locked[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("lock_hold", 32'(o_core_grant), 32'(oh(0)));
    end
    i_core_locked[0] = 1'b0;
    tick();
    chk("lock_release", 32'(o_core_grant), 32'd0);
    tick();
    chk("lock_next_grant1", 32'(o_core_grant), 32'(oh(1)));
    i_core_req[3] = 1'b1;
    session(1, 1, 0, 0);
    tick();
    chk("r2_grant3", 32'(o_core_grant), 32'(oh(3)));
    session(3, 4, 12, 4);
    drain(7, 32'hFFFF_FFFF);

    // Reset in the middle of the drain.
    reset         = 1'b1;
    i_core_req    = '0;
    i_core_locked = '0;
    tick();
    chk("midrst_grant", 32'(o_core_grant), 32'd0);
    chk("midrst_valid", 32'(o_drain_valid), 32'd0);
    chk("midrst_emptied", 32'(o_uram_emptied), 32'd1);

    // Round 3: quick sessions, full drain must restart at 0 with retained data.
    reset      = 1'b0;
    i_core_req = 4'b1111;
    for (int k = 0; k < NC; k++) begin
      tick();
      chk("r3_grant", 32'(o_core_grant), 32'(oh(k)));
      session(k, 1, 0, 0);
    end
    drain(DW, 32'b0110_1101_0011_1110_1001_0111_0101_1011);
    chk("r3_valid_end", 32'(o_drain_valid), 32'd0);
    chk("r3_emptied_rise", 32'(o_uram_emptied), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
